// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mole_round_ctrl
// Brief   : Round controller for the four-lamp reaction game. It lights a
//           pseudo-random target, scores button hits and charges lives.
// Revision: 1.0  initial release
// ============================================================================
module mole_round_ctrl #(
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES     = 12_500_000,
    parameter int          START_LIVES    = 3,
    parameter int          SCORE_W        = 8,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         btn,
    output logic [3:0]         lights,
    output logic [1:0]         target,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               game_over
);

    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_LIVES0   = 4'(START_LIVES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GAP    = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;
    localparam logic [1:0] c_OVER   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_lfsr;
    logic [3:0]         r_btn_q;
    logic [1:0]         r_target;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_lives;
    logic               r_hit;
    logic               r_miss;

    logic [3:0]         w_press;
    logic [3:0]         w_onehot;
    logic [7:0]         w_lfsr_next;

    // Buttons are active-low, so a press is a 1->0 transition.
    assign w_press     = r_btn_q & ~btn;
    assign w_onehot    = 4'b0001 << r_target;
    // Taps x^8+x^6+x^5+x^4+1 map to register bits 7,5,4,3.
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_lfsr   <= LFSR_SEED;
            r_btn_q  <= 4'b1111;
            r_target <= 2'd0;
            r_score  <= '0;
            r_lives  <= 4'd0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_btn_q <= btn;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            case (r_state)
                c_IDLE, c_OVER: begin
                    if (start) begin
                        r_score <= '0;
                        r_lives <= c_LIVES0;
                        r_cnt   <= '0;
                        r_state <= c_GAP;
                    end
                end
                c_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_target <= r_lfsr[1:0];
                        r_cnt    <= '0;
                        r_state  <= c_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ACTIVE: begin
                    if (w_press == w_onehot) begin
                        r_hit   <= 1'b1;
                        if (r_score != {SCORE_W{1'b1}}) begin
                            r_score <= r_score + 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= c_GAP;
                    end else if ((w_press != 4'b0000) || (r_cnt == c_TO_LAST)) begin
                        r_miss <= 1'b1;
                        // Guarding on <=1 keeps lives from ever wrapping.
                        if (r_lives <= 4'd1) begin
                            r_lives <= 4'd0;
                            r_state <= c_OVER;
                        end else begin
                            r_lives <= r_lives - 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign lights     = (r_state == c_ACTIVE) ? w_onehot : 4'b0000;
    assign target     = r_target;
    assign score      = r_score;
    assign lives      = r_lives;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign game_over  = (r_state == c_OVER);

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mole_round_ctrl
// Brief   : Scoreboard bench for mole_round_ctrl (plus a 2-bit-score copy).
// Revision: 1.0  initial release
// ============================================================================
module tb_mole_round_ctrl;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'hF;

    logic [3:0] lights,  lights2;
    logic [1:0] target,  target2;
    logic [7:0] score;
    logic [1:0] score2;
    logic [3:0] lives,   lives2;
    logic       hit_pulse, hit_pulse2, miss_pulse, miss_pulse2, game_over, game_over2;

    mole_round_ctrl #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2), .START_LIVES(3), .SCORE_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .lights(lights), .target(target), .score(score), .lives(lives),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    mole_round_ctrl #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2), .START_LIVES(3), .SCORE_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .lights(lights2), .target(target2), .score(score2), .lives(lives2),
        .hit_pulse(hit_pulse2), .miss_pulse(miss_pulse2), .game_over(game_over2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    logic [7:0] m_lfsr, m_lfsr_prev;
    always @(posedge clk) begin
        m_lfsr_prev <= m_lfsr;
        m_lfsr      <= rst ? lfsr_step(m_lfsr) : 8'hA5;
    end

    typedef struct {
        int         score;
        int         lives;
        logic       hit;
        logic       miss;
        logic       go;
        logic [3:0] lights;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         m_score = 0;
    int         m_lives = 0;
    logic [1:0] tgt = 2'd0;
    logic [1:0] oth;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push(input int s, input int l, input logic h, input logic m,
                        input logic g, input logic [3:0] lt);
        exp_t e;
        e.score = s; e.lives = l; e.hit = h; e.miss = m; e.go = g; e.lights = lt;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val("score",     {24'd0, score},  32'(e.score));
            check_val("score_sat", {30'd0, score2}, (e.score > 3) ? 32'd3 : 32'(e.score));
            check_val("lives",     {28'd0, lives},  32'(e.lives));
            check_val("lives_sat", {28'd0, lives2}, 32'(e.lives));
            check_val("hit",       {31'd0, hit_pulse},  {31'd0, e.hit});
            check_val("miss",      {31'd0, miss_pulse}, {31'd0, e.miss});
            check_val("game_over", {31'd0, game_over},  {31'd0, e.go});
            check_val("lights",    {28'd0, lights},  {28'd0, e.lights});
            check_val("lights_sat",{28'd0, lights2}, {28'd0, e.lights});
        end
    endtask

    task automatic begin_game();
        m_score = 0;
        m_lives = 3;
        push(m_score, m_lives, 1'b0, 1'b0, 1'b0, 4'h0);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // From GAP count 0: one dark cycle, then the terminal count lights the lamp.
    task automatic enter_active();
        push(m_score, m_lives, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc();
        cyc();
        tgt = m_lfsr_prev[1:0];
        check_val("target", {30'd0, target}, {30'd0, tgt});
        check_val("lit",    {28'd0, lights}, {28'd0, 4'b0001 << tgt});
    endtask

    task automatic wait_active(input int n);
        for (int i = 0; i < n; i++) begin
            push(m_score, m_lives, 1'b0, 1'b0, 1'b0, 4'b0001 << tgt);
            cyc();
        end
    endtask

    task automatic resolve(input logic [3:0] b, input logic is_hit);
        btn = b;
        if (is_hit) begin
            if (m_score < 255) m_score++;
            push(m_score, m_lives, 1'b1, 1'b0, 1'b0, 4'h0);
        end else begin
            m_lives--;
            push(m_score, m_lives, 1'b0, 1'b1, m_lives == 0, 4'h0);
        end
        cyc();
    endtask

    task automatic press_hit();
        resolve(~(4'b0001 << tgt), 1'b1);
    endtask

    task automatic press_wrong();
        oth = tgt + 2'd1;
        resolve(~(4'b0001 << oth), 1'b0);
    endtask

    task automatic press_double();
        oth = tgt + 2'd1;
        resolve(~((4'b0001 << tgt) | (4'b0001 << oth)), 1'b0);
    endtask

    task automatic time_out();
        wait_active(7);
        resolve(btn, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        cyc();
        push(0, 0, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc();
        check_val("rst_target", {30'd0, target}, 32'd0);
        rst = 1'b1;

        begin_game();
        enter_active();
        wait_active(2);
        press_hit();

        // Button stays held through the next round: no new press, so it times out.
        enter_active();
        time_out();
        btn = 4'hF;

        // Press on the last timeout cycle wins over the timeout.
        enter_active();
        wait_active(7);
        press_hit();
        btn = 4'hF;

        enter_active();
        press_wrong();
        btn = 4'hF;
        enter_active();
        press_double();
        btn = 4'hF;

        push(m_score, m_lives, 1'b0, 1'b0, 1'b1, 4'h0);
        cyc();
        btn = 4'hE;
        push(m_score, m_lives, 1'b0, 1'b0, 1'b1, 4'h0);
        cyc();
        btn = 4'hF;

        begin_game();
        enter_active();
        press_wrong();
        btn = 4'hF;
        enter_active();
        press_double();
        btn = 4'hF;
        enter_active();
        time_out();
        btn = 4'hF;

        begin_game();
        for (int k = 0; k < 4; k++) begin
            enter_active();
            press_hit();
            btn = 4'hF;
        end

        // Press during the dark gap is ignored and, held, never registers later.
        btn = 4'h0;
        enter_active();
        btn = 4'hF;
        wait_active(1);

        rst = 1'b0;
        btn = ~(4'b0001 << tgt);
        m_score = 0;
        m_lives = 0;
        push(0, 0, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc();
        check_val("rst2_target", {30'd0, target}, 32'd0);
        rst = 1'b1;
        btn = 4'hF;
        cyc();

        begin_game();
        enter_active();
        press_hit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
